four_input_xor_gate_b: RTL and testbench



---
 rtl/four_input_xor_gate_b_pkg.sv | 9 +
 rtl/xor2_cell.sv | 15 +
 rtl/four_input_xor_gate_b.sv | 54 +++++
 tb/tb_four_input_xor_gate_b.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/four_input_xor_gate_b_pkg.sv
// Shared constants for the four-input XOR parity cell and its pair sub-cells.
package four_input_xor_gate_b_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // Value loaded into every registered lane while rst_n is low.
  localparam logic RESET_BIT = 1'b0;

endpackage : four_input_xor_gate_b_pkg

// File: rtl/xor2_cell.sv
// Two-input, lane-wise XOR leaf used to build the parity tree.
module xor2_cell #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  // Each lane stays fully independent so an unknown on one lane never touches another.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign z[gi] = x[gi] ^ y[gi];
  end

endmodule : xor2_cell

// File: rtl/four_input_xor_gate_b.sv
// Four-input odd-parity cell: two pair XORs feed a final XOR, with a registered
// copy of every result for synchronous consumers.
module four_input_xor_gate_b
  import four_input_xor_gate_b_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] e_q,
  output logic [WIDTH-1:0] f_q,
  output logic [WIDTH-1:0] g_q
);

  xor2_cell #(.WIDTH(WIDTH)) u_xor_ab (
    .x (a),
    .y (b),
    .z (e)
  );

  xor2_cell #(.WIDTH(WIDTH)) u_xor_cd (
    .x (c),
    .y (d),
    .z (f)
  );

  // Second tree level: combining the pair results gives the 4-way parity.
  xor2_cell #(.WIDTH(WIDTH)) u_xor_ef (
    .x (e),
    .y (f),
    .z (g)
  );

  // Capture every cycle; reset clears the bank without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= {WIDTH{RESET_BIT}};
      f_q <= {WIDTH{RESET_BIT}};
      g_q <= {WIDTH{RESET_BIT}};
    end else begin
      e_q <= e;
      f_q <= f;
      g_q <= g;
    end
  end

endmodule : four_input_xor_gate_b

// File: tb/tb_four_input_xor_gate_b.sv
// Scoreboard bench for four_input_xor_gate_b at WIDTH=4: random and directed stimulus
// checked against a lane-wise count-of-ones reference.
module tb_four_input_xor_gate_b;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [W-1:0] e, f, g, e_q, f_q, g_q;

  typedef struct {
    string        tag;
    logic [W-1:0] e, f, g;
    bit           has_q;
    logic [W-1:0] eq, fq, gq;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  event comb_ev;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  four_input_xor_gate_b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .e_q   (e_q),
    .f_q   (f_q),
    .g_q   (g_q)
  );

  // Reference: per lane, count the ones; odd count means the XOR result is 1.
  function automatic exp_t model(input string tag, input logic [W-1:0] ia, ib, ic, id);
    exp_t m;
    m.tag   = tag;
    m.has_q = 1'b0;
    m.eq    = '0;
    m.fq    = '0;
    m.gq    = '0;
    for (int i = 0; i < W; i++) begin
      int n_ab, n_cd;
      n_ab = int'(ia[i]) + int'(ib[i]);
      n_cd = int'(ic[i]) + int'(id[i]);
      m.e[i] = (n_ab % 2) == 1;
      m.f[i] = (n_cd % 2) == 1;
      m.g[i] = ((n_ab + n_cd) % 2) == 1;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expectation for the combinational outputs, computed by the model.
  task automatic expect_comb(input string tag);
    comb_q.push_back(model(tag, a, b, c, d));
    ->comb_ev;
  endtask

  // Expectation with constants, optionally including the registered outputs.
  task automatic expect_const(input string tag, input logic [W-1:0] xe, xf, xg,
                              input bit hq, input logic [W-1:0] xeq, xfq, xgq);
    exp_t m;
    m.tag = tag; m.e = xe; m.f = xf; m.g = xg;
    m.has_q = hq; m.eq = xeq; m.fq = xfq; m.gq = xgq;
    comb_q.push_back(m);
    ->comb_ev;
  endtask

  // Combinational monitor.
  initial begin
    forever begin
      @(comb_ev);
      while (comb_q.size() > 0) begin
        exp_t x;
        x = comb_q.pop_front();
        $display("[%0t] comb %s a=%b b=%b c=%b d=%b e=%b f=%b g=%b", $time, x.tag, a, b, c, d, e, f, g);
        check({x.tag, ".e"}, e, x.e);
        check({x.tag, ".f"}, f, x.f);
        check({x.tag, ".g"}, g, x.g);
        if (x.has_q) begin
          check({x.tag, ".e_q"}, e_q, x.eq);
          check({x.tag, ".f_q"}, f_q, x.fq);
          check({x.tag, ".g_q"}, g_q, x.gq);
        end
      end
    end
  end

  // Predictor: what each rising edge should capture (inputs never change on an edge).
  always @(posedge clk) begin
    exp_t x;
    x = model("edge", a, b, c, d);
    if (!rst_n) begin
      x.e = '0; x.f = '0; x.g = '0;
    end
    reg_q.push_back(x);
  end

  // Registered monitor, sampling just after each edge.
  always @(posedge clk) begin
    #1;
    if (reg_q.size() > 0) begin
      exp_t x;
      x = reg_q.pop_front();
      $display("[%0t] reg e_q=%b f_q=%b g_q=%b", $time, e_q, f_q, g_q);
      check("reg.e_q", e_q, x.e);
      check("reg.f_q", f_q, x.f);
      check("reg.g_q", g_q, x.g);
    end
  end

  initial begin
    logic [3:0] code;
    // Reset state: registered outputs zero, combinational outputs live.
    #1 expect_const("reset", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed pair cases (spec vectors replicated across lanes) and lane independence.
    a = 4'b1111; b = 4'b1111; c = 4'b0000; d = 4'b1111;
    #1 expect_const("pair_1101", 4'b0000, 4'b1111, 4'b1111, 1'b0, '0, '0, '0);
    #1 a = 4'b1111; b = 4'b1111; c = 4'b1111; d = 4'b1111;
    #1 expect_const("pair_1111", 4'b0000, 4'b0000, 4'b0000, 1'b0, '0, '0, '0);
    #1 a = 4'b0000; b = 4'b1111; c = 4'b1111; d = 4'b1111;
    #1 expect_const("code_0111", 4'b1111, 4'b0000, 4'b1111, 1'b0, '0, '0, '0);
    #1 a = 4'b1010; b = 4'b0110; c = 4'b0000; d = 4'b1111;
    #1 expect_const("lanes", 4'b1100, 4'b1111, 4'b0011, 1'b0, '0, '0, '0);

    // Exhaustive sweep on lane 0: d toggles every 2 ns, c every 4, b every 8, a every 16.
    @(negedge clk);
    a[W-1:1] = W'($urandom) >> 1; b[W-1:1] = W'($urandom) >> 1;
    c[W-1:1] = W'($urandom) >> 1; d[W-1:1] = W'($urandom) >> 1;
    for (int k = 0; k < 16; k++) begin
      code = 4'(k);
      {a[0], b[0], c[0], d[0]} = code;
      #1 expect_comb($sformatf("sweep_%0d", k));
      #1;
    end

    // Registered latency: g_q follows the edge after the inputs change.
    @(negedge clk);
    a = '0; b = '0; c = '0; d = '0;
    @(negedge clk);
    a = 4'b1111;
    #2 expect_const("latency_pre", 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #2 expect_const("latency_post", 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b1111, 4'b0000, 4'b1111);

    // Asynchronous reset mid-cycle, then reload on the first edge after release.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 expect_const("async_reset", 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 expect_const("post_release", 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #2 expect_const("reload", 4'b1111, 4'b0000, 4'b1111, 1'b1, 4'b1111, 4'b0000, 4'b1111);

    // Random vectors with d toggled twice between edges.
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      #1 expect_comb($sformatf("rand_%0d", n));
      #1 d = ~d;
      #1 expect_comb($sformatf("rand_%0d_t1", n));
      #1 d = ~d;
      #1 expect_comb($sformatf("rand_%0d_t2", n));
    end

    @(negedge clk);
    #2;
    check_int("comb_queue_drained", comb_q.size(), 0);
    check_int("reg_queue_drained", reg_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_four_input_xor_gate_b
